// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if -- producer and transmitter signals of the byte queue.
//   Producer side : wr_en, wr_data, ovf_clr (in); full, empty, level, ovf (out)
//   Transmitter   : donetx (in); newd, dintx, busy (out)
// The slave modport is the queue's view, and the master modport is the
// environment's view. AW must match the AW of the attached queue.
interface uart_tx_queue_if #(
   parameter int AW = 3
);
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          ovf;
   logic          ovf_clr;
   logic          newd;
   logic [7:0]    dintx;
   logic          donetx;
   logic          busy;

   modport slave (
      input  wr_en, wr_data, ovf_clr, donetx,
      output full, empty, level, ovf, newd, dintx, busy
   );

   modport master (
      output wr_en, wr_data, ovf_clr, donetx,
      input  full, empty, level, ovf, newd, dintx, busy
   );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue -- circular byte FIFO that feeds a UART transmitter one byte
// at a time. Handshake with the transmitter: it raises newd with dintx, waits
// for a rising edge of donetx, then waits for donetx to fall before popping
// again, so that a long donetx level cannot pop twice.
//   clk : single clock, all state on posedge
//   rst : synchronous, active-high reset
//   q   : uart_tx_queue_if.slave (producer and transmitter signals)
// DEPTH must be a power of two >= 2 and AW = log2(DEPTH).
module uart_tx_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_queue_if.slave   q
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW} state_t;

   // With DEPTH = 2**AW the full level is just the top bit of level set.
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

   state_t          state, state_nxt;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     level_r, level_nxt;
   logic            full_r, empty_r, ovf_r;
   logic            newd_r, newd_nxt;
   logic [7:0]      dintx_r;
   logic            donetx_d;
   logic            wr_fire, pop, rise;

   assign wr_fire   = q.wr_en & ~full_r;
   assign rise      = q.donetx & ~donetx_d;
   assign level_nxt = level_r + (AW+1)'(wr_fire) - (AW+1)'(pop);

   // Next-state and pop decision. A pop only happens from IDLE on a
   // registered non-empty flag, so a byte written this cycle can never be
   // read in the same cycle.
   always_comb begin
      state_nxt = state;
      newd_nxt  = newd_r;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            newd_nxt = 1'b0;
            if (!empty_r) begin
               pop       = 1'b1;
               newd_nxt  = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (rise) begin
               newd_nxt  = 1'b0;
               state_nxt = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            newd_nxt = 1'b0;
            if (!q.donetx) state_nxt = IDLE;
         end
         default: begin
            newd_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         ovf_r    <= 1'b0;
         newd_r   <= 1'b0;
         dintx_r  <= 8'h00;
         donetx_d <= 1'b0;
      end else begin
         state    <= state_nxt;
         newd_r   <= newd_nxt;
         donetx_d <= q.donetx;
         if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            dintx_r <= mem[rd_ptr];
         end
         level_r <= level_nxt;
         full_r  <= (level_nxt == FULL_LVL);
         empty_r <= (level_nxt == '0);
         // A fresh overflow wins over a simultaneous clear.
         if (q.wr_en && full_r) ovf_r <= 1'b1;
         else if (q.ovf_clr)    ovf_r <= 1'b0;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_fire) mem[wr_ptr] <= q.wr_data;
   end

   assign q.full  = full_r;
   assign q.empty = empty_r;
   assign q.level = level_r;
   assign q.ovf   = ovf_r;
   assign q.newd  = newd_r;
   assign q.dintx = dintx_r;
   assign q.busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue -- directed bench for uart_tx_queue (DEPTH=8). Inputs are
// driven 1 ns after each rising edge and outputs are sampled at the same point,
// so every check sees the state that the preceding edge produced.
module tb_uart_tx_queue;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   newd_cnt = 0;
   logic newd_prev = 1'b0;
   bit   auto_done = 1'b0;
   int   dcnt = 0;
   logic [7:0] got[$];

   uart_tx_queue_if #(.AW(3)) bus ();

   uart_tx_queue #(.DEPTH(8), .AW(3)) dut (
      .clk (clk),
      .rst (rst),
      .q   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; records each newd rising edge and, when enabled, plays
   // a transmitter that answers newd with a 3-cycle donetx pulse.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.newd && !newd_prev) begin
         got.push_back(bus.dintx);
         newd_cnt++;
      end
      newd_prev = bus.newd;
      if (auto_done) begin
         if (bus.donetx) begin
            dcnt++;
            if (dcnt == 3) bus.donetx = 1'b0;
         end else if (bus.newd) begin
            bus.donetx = 1'b1;
            dcnt = 0;
         end
      end
   endtask

   task automatic complete();
      bus.donetx = 1'b1;
      repeat (3) tick();
      bus.donetx = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   initial begin
      int snap;
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.ovf_clr = 1'b0;
      bus.donetx  = 1'b0;
      tick();
      do_reset();

      // Reset state
      chk("rst_empty", bus.empty, 1);
      chk("rst_full",  bus.full,  0);
      chk("rst_level", bus.level, 0);
      chk("rst_ovf",   bus.ovf,   0);
      chk("rst_newd",  bus.newd,  0);
      chk("rst_dintx", bus.dintx, 8'h00);
      chk("rst_busy",  bus.busy,  0);

      // Single byte: write then pop one edge later
      wr(8'hA5);
      chk("s_lvl1",   bus.level, 1);
      chk("s_newd0",  bus.newd,  0);
      tick();
      chk("s_newd1",  bus.newd,  1);
      chk("s_dintx",  bus.dintx, 8'hA5);
      chk("s_busy1",  bus.busy,  1);
      chk("s_lvl0",   bus.level, 0);
      bus.donetx = 1'b1;
      tick();
      chk("s_newd_fall", bus.newd, 0);
      tick(); tick();
      chk("s_busy_wl", bus.busy, 1);
      bus.donetx = 1'b0;
      tick();
      chk("s_busy_end", bus.busy, 0);

      // Ordering of three back-to-back writes
      newd_cnt = 0;
      got.delete();
      wr(8'h11); wr(8'h22); wr(8'h33);
      chk("o_dintx11", bus.dintx, 8'h11);
      chk("o_lvl2",    bus.level, 2);
      complete(); tick();
      chk("o_dintx22", bus.dintx, 8'h22);
      chk("o_lvl1",    bus.level, 1);
      complete(); tick();
      chk("o_dintx33", bus.dintx, 8'h33);
      complete();
      chk("o_newd_cnt", newd_cnt, 3);
      chk("o_lvl_end",  bus.level, 0);
      chk("o_busy_end", bus.busy, 0);

      // Overflow: ten writes with the transmitter stalled
      for (int i = 0; i < 10; i++) wr(8'(i));
      chk("v_lvl8",  bus.level, 8);
      chk("v_full",  bus.full,  1);
      chk("v_ovf",   bus.ovf,   1);
      chk("v_dintx", bus.dintx, 8'h00);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      chk("v_ovf_clr", bus.ovf, 0);
      for (int k = 1; k <= 8; k++) begin
         complete(); tick();
         chk($sformatf("v_drain%0d", k), bus.dintx, 32'(k));
      end
      complete();
      chk("v_empty_end", bus.empty, 1);
      chk("v_lvl_end",   bus.level, 0);

      // Simultaneous write+pop, then overflow beats ovf_clr
      do_reset();
      wr(8'hC0); wr(8'hC1); wr(8'hC2); wr(8'hC3);
      complete();
      chk("m_lvl3_idle", bus.level, 3);
      chk("m_idle",      bus.busy, 0);
      wr(8'hC4);
      chk("m_lvl_same",  bus.level, 3);
      chk("m_dintx",     bus.dintx, 8'hC1);
      for (int i = 5; i <= 9; i++) wr(8'hC0 + 8'(i));
      chk("m_full",  bus.full, 1);
      chk("m_ovf0",  bus.ovf,  0);
      bus.ovf_clr = 1'b1;
      wr(8'hCA);
      bus.ovf_clr = 1'b0;
      chk("m_ovf_wins", bus.ovf,   1);
      chk("m_lvl8",     bus.level, 8);

      // Reset while SEND with four bytes queued
      do_reset();
      for (int i = 0; i < 5; i++) wr(8'hD0 + 8'(i));
      chk("r_lvl4", bus.level, 4);
      chk("r_send", bus.newd,  1);
      do_reset();
      chk("r_newd",  bus.newd,  0);
      chk("r_lvl0",  bus.level, 0);
      chk("r_empty", bus.empty, 1);
      chk("r_busy",  bus.busy,  0);
      chk("r_ovf",   bus.ovf,   0);
      snap = newd_cnt;
      complete();
      tick();
      chk("r_nopop_newd", newd_cnt, snap);
      chk("r_nopop_busy", bus.busy, 0);

      // Pointer wrap: 20 bytes streamed against a responding transmitter
      newd_cnt = 0;
      got.delete();
      auto_done = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr(8'h40 + 8'(i));
         repeat (3) tick();
      end
      for (int b = 0; b < 300; b++) begin
         if (got.size() == 20 && bus.empty && !bus.busy && !bus.donetx) break;
         tick();
      end
      auto_done = 1'b0;
      chk("w_count", got.size(), 20);
      for (int k = 0; k < got.size(); k++)
         chk($sformatf("w_byte%0d", k), got[k], 8'h40 + 8'(k));
      chk("w_ovf",   bus.ovf,   0);
      chk("w_empty", bus.empty, 1);
      chk("w_newd_cnt", newd_cnt, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of byte entries; SHALL be a power of two, at least 2.
REQ-002 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock for the whole block; all state SHALL update on posedge clk only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_en  input  1  producer write strobe; one byte accepted per clk cycle.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 full  output  1  high when level equals DEPTH.
REQ-008 empty  output  1  high when level equals 0.
REQ-009 level  output  AW+1  number of stored bytes, 0 to DEPTH.
REQ-010 ovf  output  1  sticky overflow flag.
REQ-011 ovf_clr  input  1  clears ovf.
REQ-012 newd  output  1  request to the transmitter; SHALL connect to the transmitter newd input.
REQ-013 dintx  output  8  byte being sent; SHALL connect to the transmitter byte input.
REQ-014 donetx  input  1  transmitter completion level; SHALL be high for one or more clk cycles.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH x 8 bits, with AW-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-017 A write SHALL occur when wr_en=1 and full=0: store wr_data at the write pointer, then increment the write pointer.
REQ-018 wr_en=1 with full=1 SHALL drop the byte, leave the buffer and pointers unchanged, and set ovf=1 on the next edge.
REQ-019 ovf SHALL stay set until ovf_clr=1 or rst=1; if ovf_clr and a new overflow occur in the same cycle, ovf SHALL be 1.
REQ-020 The FSM SHALL have three states: IDLE, SEND, WAIT_LOW.
REQ-021 IDLE with empty=0: on the edge, load dintx from the read pointer, increment the read pointer, set newd=1, and go to SEND.
REQ-022 IDLE with empty=1: remain in IDLE with newd=0.
REQ-023 The block SHALL register donetx as donetx_d; rise SHALL mean donetx=1 and donetx_d=0.
REQ-024 SEND: newd and dintx SHALL be held stable; on rise, set newd=0 and go to WAIT_LOW; with no rise, stay in SEND.
REQ-025 WAIT_LOW: when donetx=0, go to IDLE; otherwise stay in WAIT_LOW. This prevents a long donetx level from triggering a second pop.
REQ-026 A write and a pop in the same cycle SHALL both take effect; level SHALL be unchanged.
REQ-027 level, full and empty SHALL be registered and consistent with the pointers after every edge.
REQ-028 Latency: a byte written into an empty queue at edge N with the FSM in IDLE SHALL give newd=1 and the correct dintx after edge N+1.
REQ-029 Write-through is forbidden: a pop SHALL read only entries written on a previous edge.
REQ-030 Bytes SHALL leave in write order, with no loss or duplication, while ovf=0.
REQ-031 In SEND and WAIT_LOW, writes SHALL continue to be accepted until full.

Reset
REQ-032 rst=1 at any posedge clk SHALL set: state=IDLE, both pointers=0, level=0, empty=1, full=0, ovf=0, newd=0, dintx=8'h00, busy=0, donetx_d=0.
REQ-033 rst during SEND SHALL discard the in-flight byte and all queued bytes.
REQ-034 rst SHALL take priority over wr_en, ovf_clr and donetx.
REQ-035 Buffer RAM contents need not be cleared.

Verification
REQ-036 Single byte: reset, then write 8'hA5 at cycle 0 -> newd=1 and dintx=8'hA5 at cycle 1; pulse donetx high for 3 cycles -> newd=0 one cycle after the rise, and busy=0 after donetx falls.
REQ-037 Ordering: write 8'h11, 8'h22, 8'h33 back-to-back, each completed by a 3-cycle donetx pulse -> dintx sequence is 11, 22, 33; exactly three newd assertions; level returns to 0.
REQ-038 Overflow (DEPTH=8): hold donetx=0; write 10 bytes 8'h00..8'h09 -> first byte popped, level=8, full=1, ovf=1, 8'h09 dropped; ovf_clr pulse -> ovf=0.
REQ-039 Simultaneous events: with level=3 in IDLE, wr_en=1 on the pop cycle -> level stays 3; then a write with ovf_clr=1 on a full queue -> ovf=1.
REQ-040 Pointer wrap: stream 20 bytes 8'h40..8'h53 with interleaved completions -> all 20 delivered in order; no ovf; empty=1 at the end.
REQ-041 Reset mid-operation: assert rst in SEND with level=4 -> next cycle newd=0, level=0, empty=1, busy=0; a following donetx pulse causes no pop.
